// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the two-client APB master arbiter.
package apb_ctrl_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  localparam int CLI0 = 0;
  localparam int CLI1 = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; owns the priority pointer, which moves past the winner on each grant.
module rr_arb2
  import apb_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic pointer_q;
  logic pointer_d;

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = pointer_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // A grant to client 0 hands priority to client 1 and vice versa.
  always_comb begin
    pointer_d = pointer_q;
    if (advance_i && (|grant_o)) begin
      pointer_d = grant_o[CLI0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pointer_q <= 1'b0;
    end else begin
      pointer_q <= pointer_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-client APB master: round-robin grant, IDLE/SETUP/ACCESS sequencing, per-client responses.
// Optional ACCESS timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                Pclk,
  input  logic                Prst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                Pselx,
  output logic                Penable,
  output logic                Pwrite,
  output logic [ADDR_W-1:0]   Paddr,
  output logic [DATA_W-1:0]   Pwdata,
  input  logic                Pready,
  input  logic                Pslverr,
  input  logic [DATA_W-1:0]   Prdata
);

  apb_state_e          state_q;
  logic                pselx_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                owner_q;
  logic [1:0]          respValid_q;
  logic [DATA_W-1:0]   respRdata_q;
  logic                respErr_q;

  logic [1:0]          grant;
  logic                grantPoint;
  logic                doGrant;
  logic                complete;
  logic                tmoHit;
  logic                selIdx;
  logic                selWrite;
  logic [ADDR_W-1:0]   selAddr;
  logic [DATA_W-1:0]   selWdata;

  assign grantPoint = (state_q == IDLE) || ((state_q == ACCESS) && Pready);
  assign doGrant    = grantPoint && (|req_valid) && !Prst;
  assign complete   = (state_q == ACCESS) && Pready;
  assign req_ready  = doGrant ? grant : 2'b00;

  assign selIdx   = grant[CLI1];
  assign selWrite = req_write[selIdx];
  assign selAddr  = selIdx ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
  assign selWdata = selIdx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  rr_arb2 u_arb (
    .clk_i     (Pclk),
    .rst_i     (Prst),
    .req_i     (req_valid),
    .advance_i (doGrant),
    .grant_o   (grant)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmoCnt_q;

  // Counts consecutive not-ready ACCESS cycles; any other cycle clears it.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      tmoCnt_q <= '0;
    end else if ((state_q == ACCESS) && !Pready) begin
      tmoCnt_q <= tmoCnt_q + 1'b1;
    end else begin
      tmoCnt_q <= '0;
    end
  end

  assign tmoHit = (state_q == ACCESS) && !Pready && (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmoHit = 1'b0;
`endif

  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      state_q     <= IDLE;
      pselx_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      owner_q     <= 1'b0;
      respValid_q <= 2'b00;
      respRdata_q <= '0;
      respErr_q   <= 1'b0;
    end else begin
      respValid_q <= 2'b00;

      if (complete) begin
        respValid_q[owner_q] <= 1'b1;
        respRdata_q          <= pwrite_q ? '0 : Prdata;
        respErr_q            <= Pslverr;
      end else if (tmoHit) begin
        respValid_q[owner_q] <= 1'b1;
        respRdata_q          <= '0;
        respErr_q            <= 1'b1;
      end

      // A new grant always launches SETUP, even straight out of a completing ACCESS.
      if (doGrant) begin
        state_q   <= SETUP;
        pselx_q   <= 1'b1;
        penable_q <= 1'b0;
        pwrite_q  <= selWrite;
        paddr_q   <= selAddr;
        pwdata_q  <= selWdata;
        owner_q   <= selIdx;
      end else begin
        unique case (state_q)
          SETUP: begin
            state_q   <= ACCESS;
            penable_q <= 1'b1;
          end
          ACCESS: begin
            if (complete || tmoHit) begin
              state_q   <= IDLE;
              pselx_q   <= 1'b0;
              penable_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= IDLE;
            pselx_q   <= 1'b0;
            penable_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Pselx      = pselx_q;
  assign Penable    = penable_q;
  assign Pwrite     = pwrite_q;
  assign Paddr      = paddr_q;
  assign Pwdata     = pwdata_q;
  assign resp_valid = respValid_q;
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a 32-word APB memory model; timeout case follows APB_TIMEOUT_EN.
module tb_apb_master_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          Pclk = 1'b0;
  logic          Prst;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          Pselx;
  logic          Penable;
  logic          Pwrite;
  logic [AW-1:0] Paddr;
  logic [DW-1:0] Pwdata;
  logic          Pready;
  logic          Pslverr;
  logic [DW-1:0] Prdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [32] = '{default: '0};

  apb_master_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .Pclk       (Pclk),
    .Prst       (Prst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .Pselx      (Pselx),
    .Penable    (Penable),
    .Pwrite     (Pwrite),
    .Paddr      (Paddr),
    .Pwdata     (Pwdata),
    .Pready     (Pready),
    .Pslverr    (Pslverr),
    .Prdata     (Prdata)
  );

  always #5 Pclk = ~Pclk;

  // Memory slave: writes land on the completing ACCESS edge, reads are combinational.
  always @(posedge Pclk) begin
    if (Pselx && Penable && Pready && Pwrite) mem[Paddr] <= Pwdata;
  end
  assign Prdata = mem[Paddr];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  // Present a request and hold it until the acceptance edge; returns 1ns after that edge.
  task automatic issue(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[c] = 1'b1;
    req_write[c] = wr;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*DW +: DW] = d;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[c]) begin
        tick();
        req_valid[c] = 1'b0;
        return;
      end
      tick();
    end
    checks++; errors++;
    $display("[TB] FAIL issue_accept client %0d got req_ready=%b want bit set", c, req_ready);
    req_valid[c] = 1'b0;
  endtask

  task automatic test_reset();
    Prst = 1'b1; req_valid = 2'b11; req_write = 2'b11;
    req_addr = '1; req_wdata = '1; Pready = 1'b1; Pslverr = 1'b0;
    #2;
    checks++; if (Pselx !== 1'b0) begin errors++; $display("[TB] FAIL rst_pselx got %b want 0", Pselx); end
    checks++; if (Penable !== 1'b0) begin errors++; $display("[TB] FAIL rst_penable got %b want 0", Penable); end
    checks++; if ({Pwrite, Paddr, Pwdata} !== '0) begin errors++; $display("[TB] FAIL rst_apb_fields got %b/%h/%h want 0", Pwrite, Paddr, Pwdata); end
    checks++; if ({resp_valid, resp_rdata, resp_err} !== '0) begin errors++; $display("[TB] FAIL rst_resp got %b/%h/%b want 0", resp_valid, resp_rdata, resp_err); end
    tick(); tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rst_req_ready got %b want 00", req_ready); end
    req_valid = 2'b00;
    @(negedge Pclk); Prst = 1'b0;
    tick();
    checks++; if (Pselx !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_after got %b want 0", Pselx); end
  endtask

  task automatic test_write_read();
    Pready = 1'b1; Pslverr = 1'b0;
    issue(0, 1'b1, 5'd5, 32'hDEADBEEF);
    checks++; if ({Pselx, Penable} !== 2'b10) begin errors++; $display("[TB] FAIL wr_setup got sel/en=%b want 10", {Pselx, Penable}); end
    checks++; if ({Pwrite, Paddr, Pwdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL wr_fields got %b/%0d/%h want 1/5/deadbeef", Pwrite, Paddr, Pwdata); end
    tick();
    checks++; if ({Pselx, Penable, resp_valid} !== 4'b1100) begin errors++; $display("[TB] FAIL wr_access got sel/en/rv=%b want 1100", {Pselx, Penable, resp_valid}); end
    tick();
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("[TB] FAIL wr_resp_valid got %b want 01", resp_valid); end
    checks++; if ({resp_err, resp_rdata} !== 33'd0) begin errors++; $display("[TB] FAIL wr_resp_data got %b/%h want 0/0", resp_err, resp_rdata); end
    checks++; if (Pselx !== 1'b0) begin errors++; $display("[TB] FAIL wr_to_idle got %b want 0", Pselx); end
    issue(0, 1'b0, 5'd5, 32'h0);
    tick(); tick();
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("[TB] FAIL rd_resp_valid got %b want 01", resp_valid); end
    checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_rdata got %h want deadbeef", resp_rdata); end
    tick();
    checks++; if ({resp_valid, resp_rdata} !== {2'b00, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL rd_hold got %b/%h want 00/deadbeef", resp_valid, resp_rdata); end
  endtask

  task automatic test_contention();
    @(negedge Pclk); Prst = 1'b1;
    @(negedge Pclk); Prst = 1'b0;
    Pready = 1'b1;
    req_write = 2'b11;
    req_addr = {5'd2, 5'd1};
    req_wdata = {32'h22, 32'h11};
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL arb_first got %b want 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    #1;
    checks++; if ({req_ready, Pselx, Penable, Paddr} !== {2'b00, 2'b10, 5'd1}) begin errors++; $display("[TB] FAIL arb_setup0 got rdy=%b sel/en=%b addr=%0d want 00/10/1", req_ready, {Pselx, Penable}, Paddr); end
    tick();
    checks++; if ({Penable, req_ready} !== 3'b110) begin errors++; $display("[TB] FAIL arb_access0 got en/rdy=%b want 110", {Penable, req_ready}); end
    tick();
    req_valid[1] = 1'b0;
    checks++; if ({resp_valid, Pselx, Penable, Paddr} !== {2'b01, 2'b10, 5'd2}) begin errors++; $display("[TB] FAIL arb_b2b got rv=%b sel/en=%b addr=%0d want 01/10/2", resp_valid, {Pselx, Penable}, Paddr); end
    tick();
    checks++; if ({Pselx, Penable, resp_valid} !== 4'b1100) begin errors++; $display("[TB] FAIL arb_access1 got %b want 1100", {Pselx, Penable, resp_valid}); end
    tick();
    checks++; if ({resp_valid, Pselx} !== 3'b100) begin errors++; $display("[TB] FAIL arb_done1 got rv/sel=%b want 100", {resp_valid, Pselx}); end
    req_addr = {5'd4, 5'd3};
    req_wdata = {32'h44, 32'h33};
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL arb_second_pair got %b want 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick(); tick();
    req_valid[1] = 1'b0;
    checks++; if ({resp_valid, Paddr} !== {2'b01, 5'd4}) begin errors++; $display("[TB] FAIL arb_pair2_b2b got rv=%b addr=%0d want 01/4", resp_valid, Paddr); end
    tick(); tick();
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("[TB] FAIL arb_pair2_done got %b want 10", resp_valid); end
  endtask

  task automatic test_wait_states();
    int pulses;
    pulses = 0;
    Pready = 1'b0;
    issue(1, 1'b1, 5'd7, 32'h12345678);
    checks++; if ({Pselx, Penable} !== 2'b10) begin errors++; $display("[TB] FAIL ws_setup got %b want 10", {Pselx, Penable}); end
    tick();
    for (int i = 0; i < 3; i++) begin
      pulses += int'(resp_valid[1]);
      checks++; if ({Penable, Pwrite, Paddr, Pwdata} !== {2'b11, 5'd7, 32'h12345678}) begin errors++; $display("[TB] FAIL ws_hold%0d got en=%b wr=%b addr=%0d data=%h want 1/1/7/12345678", i, Penable, Pwrite, Paddr, Pwdata); end
      tick();
    end
    Pready = 1'b1;
    checks++; if ({Penable, Paddr, Pwdata} !== {1'b1, 5'd7, 32'h12345678}) begin errors++; $display("[TB] FAIL ws_last got en=%b addr=%0d data=%h want 1/7/12345678", Penable, Paddr, Pwdata); end
    tick();
    pulses += int'(resp_valid[1]);
    checks++; if (resp_valid !== 2'b10) begin errors++; $display("[TB] FAIL ws_resp got %b want 10", resp_valid); end
    tick();
    pulses += int'(resp_valid[1]);
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL ws_pulse_count got %0d want 1", pulses); end
    checks++; if (Penable !== 1'b0) begin errors++; $display("[TB] FAIL ws_idle got %b want 0", Penable); end
  endtask

  task automatic test_error();
    Pready = 1'b1; Pslverr = 1'b1;
    issue(1, 1'b0, 5'd5, 32'h0);
    tick(); tick();
    checks++; if ({resp_valid, resp_err} !== 3'b101) begin errors++; $display("[TB] FAIL err_resp got rv/err=%b want 101", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL err_rdata got %h want deadbeef", resp_rdata); end
    Pslverr = 1'b0;
    issue(0, 1'b0, 5'd7, 32'h0);
    tick(); tick();
    checks++; if ({resp_valid, resp_err} !== 3'b010) begin errors++; $display("[TB] FAIL err_clear got rv/err=%b want 010", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL err_next_rdata got %h want 12345678", resp_rdata); end
  endtask

  task automatic test_timeout();
    Pready = 1'b0;
    issue(0, 1'b0, 5'd9, 32'h0);
    tick();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      checks++; if ({Pselx, Penable, resp_valid} !== 4'b1100) begin errors++; $display("[TB] FAIL tmo_wait%0d got %b want 1100", i, {Pselx, Penable, resp_valid}); end
      tick();
    end
    checks++; if ({Pselx, Penable, resp_valid, resp_err} !== 5'b00011) begin errors++; $display("[TB] FAIL tmo_abort got sel/en/rv/err=%b want 00011", {Pselx, Penable, resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL tmo_rdata got %h want 0", resp_rdata); end
    Pready = 1'b1;
    tick();
`else
    for (int i = 0; i < 10; i++) begin
      checks++; if ({Pselx, Penable, resp_valid} !== 4'b1100) begin errors++; $display("[TB] FAIL notmo_wait%0d got %b want 1100", i, {Pselx, Penable, resp_valid}); end
      tick();
    end
    Pready = 1'b1;
    tick();
    checks++; if ({resp_valid, resp_err} !== 3'b010) begin errors++; $display("[TB] FAIL notmo_done got rv/err=%b want 010", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL notmo_rdata got %h want 0", resp_rdata); end
`endif
  endtask

  task automatic test_reset_midtransfer();
    Pready = 1'b1;
    issue(0, 1'b0, 5'd5, 32'h0);
    tick(); tick();
    checks++; if ({resp_valid, resp_rdata} !== {2'b01, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL mr_pre_read got %b/%h want 01/deadbeef", resp_valid, resp_rdata); end
    Pready = 1'b0;
    issue(1, 1'b1, 5'd2, 32'hAAAA5555);
    tick(); tick();
    Prst = 1'b1;
    #1;
    checks++; if ({Pselx, Penable, Paddr} !== '0) begin errors++; $display("[TB] FAIL mr_apb_clear got sel/en=%b addr=%0d want 00/0", {Pselx, Penable}, Paddr); end
    checks++; if ({resp_valid, resp_rdata, resp_err} !== '0) begin errors++; $display("[TB] FAIL mr_resp_clear got %b/%h/%b want 0", resp_valid, resp_rdata, resp_err); end
    @(negedge Pclk); Prst = 1'b0;
    Pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({resp_valid, Pselx} !== 3'b000) begin errors++; $display("[TB] FAIL mr_after%0d got rv/sel=%b want 000", i, {resp_valid, Pselx}); end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_write_read();
    test_contention();
    test_wait_states();
    test_error();
    test_timeout();
    test_reset_midtransfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master that shares the single APB_Memory slave (32 x 32-bit) between two on-chip clients.
- Arbitrates round-robin between the two clients and sequences the APB IDLE/SETUP/ACCESS phases.
- Honours Pready wait states and returns read data and error status to the granted client.
- Sits directly in front of the APB_Memory slave port.

Parameters:
- ADDR_W, 5, Paddr width (32 words).
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort. Used only with APB_TIMEOUT_EN.

Ports:
- Pclk  in  1  single clock for the whole block; all state changes on posedge.
- Prst  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-client request; bit i = client i.
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  2*ADDR_W  client i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  client i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  2  request accepted (combinational).
- resp_valid  out  2  one-cycle completion pulse per client.
- resp_rdata  out  DATA_W  read data; 0 for writes.
- resp_err  out  1  Pslverr (or timeout) for the completing transfer.
- Pselx  out  1  APB select.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Paddr  out  ADDR_W  APB address.
- Pwdata  out  DATA_W  APB write data.
- Pready  in  1  slave ready.
- Pslverr  in  1  slave error.
- Prdata  in  DATA_W  slave read data.

Behaviour:
- Reset (Prst=1, asynchronous):
  - State IDLE, priority pointer = 0.
  - Pselx, Penable, Pwrite, Paddr, Pwdata, resp_valid, resp_rdata and resp_err all 0.
  - req_ready = 0 while Prst is high.
  - Reset mid-transfer abandons the transfer: no resp_valid, no grant retained.
- FSM states:
  - IDLE: Pselx=0, Penable=0.
  - SETUP: Pselx=1, Penable=0; always exactly one cycle, then ACCESS.
  - ACCESS: Pselx=1, Penable=1; held until Pready=1 is sampled at a posedge.
- Grant points: in IDLE, or in ACCESS with Pready=1 (completion cycle).
  - If any req_valid is high, the round-robin winner g gets req_ready[g]=1 in that cycle.
  - At that posedge: req_write, addr and wdata of g are registered onto Pwrite/Paddr/Pwdata; FSM goes to SETUP.
- Completion without a pending request: FSM goes to IDLE.
  - Back-to-back case: Pselx stays 1 and Penable drops for exactly one SETUP cycle.
- Round-robin arbitration:
  - If only one client is valid, it wins.
  - If both are valid, the client equal to the pointer wins.
  - After granting g, pointer = 1-g.
- Handshake:
  - A client holds req_valid and its fields stable until it sees req_ready=1 at a posedge.
  - Dropping req_valid early is allowed and has no effect.
- Latency (request accepted at edge N, slave with zero wait states):
  - Pselx=1 after N.
  - Penable=1 after N+1.
  - Pready sampled at N+2.
  - resp_valid[g]=1 for the one cycle after N+2.
- Response contents:
  - resp_rdata = Prdata for reads, 0 for writes.
  - resp_err = Pslverr, sampled only when Pready=1.
  - resp_rdata and resp_err hold their values until the next completion.
- Wait states: Paddr, Pwrite and Pwdata stay stable from SETUP through the final ACCESS cycle; Penable stays 1 throughout.
- Outside transfers: Paddr and Pwdata retain their last values in IDLE.
- Address range: addresses are ADDR_W wide, so no out-of-range access is possible.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - If Pready stays 0 for TIMEOUT_CYCLES consecutive ACCESS cycles, the transfer aborts: Pselx=0, Penable=0, next state IDLE.
  - resp_valid[g]=1 with resp_err=1 and resp_rdata=0.
  - The pointer advances as for a normal completion.
- Undefined:
  - No counter exists.
  - ACCESS waits indefinitely for Pready.

Decomposition:
- Package apb_ctrl_pkg:
  - state encoding IDLE/SETUP/ACCESS;
  - ADDR_W and DATA_W defaults;
  - client index constants CLI0=0 and CLI1=1.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], pointer, advance.
  - Output: one-hot grant.
  - Holds the pointer register.

Test Plan:
- Reset: assert Prst=1 in the middle of ACCESS → Pselx, Penable and all resp outputs go to 0 immediately; no resp_valid after Prst=0.
- Single write then read, Pready tied 1:
  - req0 write addr 5, data 0xDEADBEEF accepted at edge N → Pselx after N, Penable after N+1, resp_valid[0] after N+2, resp_err=0.
  - Follow-up read of addr 5 → resp_rdata=0xDEADBEEF.
- Contention: both clients valid in the same cycle after reset → client 0 served first, then client 1 back-to-back with Pselx held 1 and one Penable=0 cycle; a second simultaneous request pair is served client 0 first again.
- Wait states: Pready=0 for 3 ACCESS cycles → Penable high for 4 cycles, Paddr/Pwdata unchanged throughout, exactly one resp_valid pulse.
- Error: Pslverr=1 with Pready=1 on a client 1 read → resp_valid[1]=1, resp_err=1; the next transfer with Pslverr=0 reports resp_err=0.
- Timeout: with APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, Pready stuck at 0 → abort after 4 ACCESS cycles with resp_err=1 and resp_rdata=0; without the macro the FSM stays in ACCESS.
